// File: rtl/fb_pkg.sv
// Shared definitions for the framebuffer pixel writer.
// Holds the write FSM state encoding, the address/pixel widths and a
// helper that maps the byte-address LSB onto the active-low SRAM byte lanes.
package fb_pkg;

    localparam int FB_ADDR_W   = 19;
    localparam int SRAM_ADDR_W = 18;
    localparam int PIX_W       = 8;
    localparam int ENTRY_W     = FB_ADDR_W + PIX_W;

    typedef enum logic [1:0] {
        FSM_IDLE    = 2'd0,
        FSM_SETUP   = 2'd1,
        FSM_STROBE  = 2'd2,
        FSM_RECOVER = 2'd3
    } fsm_state_t;

    // Returns {ub, lb}, active low. Odd byte addresses live in the upper lane.
    function automatic logic [1:0] lane_sel(input logic addr_lsb);
        return addr_lsb ? 2'b01 : 2'b10;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy counter.
// Ports: clk, n_reset (async active-low), i_push/i_din write side,
// i_pop/o_dout read side (o_dout shows the head combinationally),
// o_full, o_empty, o_level (occupancy, 0..DEPTH).
// Push while full and pop while empty are ignored.
module sync_fifo #(
    parameter int WIDTH = 27,
    parameter int DEPTH = 8,
    parameter int LVL_W = 4
) (
    input  logic             clk,
    input  logic             n_reset,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_din,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_dout,
    output logic             o_full,
    output logic             o_empty,
    output logic [LVL_W-1:0] o_level
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [LVL_W-1:0] r_level;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_level == LVL_W'(DEPTH));
    assign o_empty   = (r_level == '0);
    assign o_level   = r_level;
    assign o_dout    = r_mem[r_rd_ptr];
    assign w_do_push = i_push & ~o_full;
    assign w_do_pop  = i_pop & ~o_empty;

    // Storage needs no reset: flushing is done by clearing pointers and level.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_din;
        end
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_level <= r_level + LVL_W'(1);
                2'b01:   r_level <= r_level - LVL_W'(1);
                default: r_level <= r_level;
            endcase
        end
    end

endmodule

// File: rtl/fb_pixel_writer.sv
// Framebuffer pixel writer: buffers byte-addressed RGB332 pixel writes and
// commits them to the 16-bit SRAM only while the top level grants the bus.
// Ports: clk, n_reset (async active-low); bus_free (bus grant);
// wr_valid/wr_ready/wr_addr/wr_data (pixel write request);
// sram_own, sramAddr, sramDataOut, sram_we, sram_oe, sram_ub, sram_lb (SRAM side);
// fifo_level (queued pixels), write_count (completed writes, wraps at 2^16).
//
// state       | meaning
// ------------+----------------------------------------------------------
// FSM_IDLE    | bus released, strobes inactive, output regs hold
// FSM_SETUP   | bus owned, address/data/lanes settle, we high
// FSM_STROBE  | we low for one cycle
// FSM_RECOVER | we high, everything held; next entry may be popped
module fb_pixel_writer
    import fb_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int LVL_W      = 4
) (
    input  logic                   clk,
    input  logic                   n_reset,
    input  logic                   bus_free,
    input  logic                   wr_valid,
    output logic                   wr_ready,
    input  logic [FB_ADDR_W-1:0]   wr_addr,
    input  logic [PIX_W-1:0]       wr_data,
    output logic                   sram_own,
    output logic [SRAM_ADDR_W-1:0] sramAddr,
    output logic [15:0]            sramDataOut,
    output logic                   sram_we,
    output logic                   sram_oe,
    output logic                   sram_ub,
    output logic                   sram_lb,
    output logic [LVL_W-1:0]       fifo_level,
    output logic [15:0]            write_count
);

    fsm_state_t r_state;
    fsm_state_t w_next_state;

    logic                   w_full;
    logic                   w_empty;
    logic                   w_pop;
    logic [ENTRY_W-1:0]     w_head;
    logic [SRAM_ADDR_W-1:0] r_addr;
    logic [PIX_W-1:0]       r_data;
    logic                   r_ub;
    logic                   r_lb;
    logic [15:0]            r_write_count;

    assign wr_ready = ~w_full;

    sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH),
        .LVL_W (LVL_W)
    ) u_fifo (
        .clk     (clk),
        .n_reset (n_reset),
        .i_push  (wr_valid),
        .i_din   ({wr_addr, wr_data}),
        .i_pop   (w_pop),
        .o_dout  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_level (fifo_level)
    );

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_state <= FSM_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // bus_free is only looked at in IDLE and RECOVER, so a started write
    // always runs to completion.
    always_comb begin
        w_next_state = r_state;
        w_pop        = 1'b0;
        case (r_state)
            FSM_IDLE: begin
                if (!w_empty && bus_free) begin
                    w_next_state = FSM_SETUP;
                    w_pop        = 1'b1;
                end
            end
            FSM_SETUP:  w_next_state = FSM_STROBE;
            FSM_STROBE: w_next_state = FSM_RECOVER;
            FSM_RECOVER: begin
                if (!w_empty && bus_free) begin
                    w_next_state = FSM_SETUP;
                    w_pop        = 1'b1;
                end else begin
                    w_next_state = FSM_IDLE;
                end
            end
            default: w_next_state = FSM_IDLE;
        endcase
    end

    // Strobes decode directly from the state register so an async reset
    // releases the bus without waiting for a clock edge.
    always_comb begin
        sram_own = (r_state != FSM_IDLE);
        sram_we  = (r_state != FSM_STROBE);
        sram_ub  = sram_own ? r_ub : 1'b1;
        sram_lb  = sram_own ? r_lb : 1'b1;
    end

    assign sram_oe     = 1'b1;
    assign sramAddr    = r_addr;
    assign sramDataOut = {r_data, r_data};
    assign write_count = r_write_count;

    // Head entry layout: {addr[18:0], data[7:0]}.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_addr        <= '0;
            r_data        <= '0;
            r_ub          <= 1'b1;
            r_lb          <= 1'b1;
            r_write_count <= '0;
        end else begin
            if (w_pop) begin
                r_addr       <= w_head[ENTRY_W-1:PIX_W+1];
                r_data       <= w_head[PIX_W-1:0];
                {r_ub, r_lb} <= lane_sel(w_head[PIX_W]);
            end
            if (r_state == FSM_STROBE) begin
                r_write_count <= r_write_count + 16'd1;
            end
        end
    end

endmodule
